// File: rtl/shared_comparator_arbiter_pkg.sv
// Shared types and defaults for shared_comparator_arbiter.
package shared_comparator_arbiter_pkg;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_NUM_REQ  = 4;
    localparam int unsigned RSP_ID_MAX_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [RSP_ID_MAX_W-1:0] id;
        logic                    lt;
        logic                    eq;
        logic                    gt;
    } rsp_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 == n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/shared_comparator_arbiter_rr_picker.sv
// Round-robin picker: first valid requester at or after ptr_i, with wrap.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    always_comb begin
        logic [ID_W-1:0] sel;
        sel     = '0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sel = ID_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_valid_i[sel]) begin
                any_o        = 1'b1;
                grant_o[sel] = 1'b1;
                idx_o        = sel;
            end
        end
    end

endmodule

// File: rtl/unsigned_comparator.sv
// Combinational unsigned magnitude comparator.
module unsigned_comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o
);

    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);

endmodule

// File: rtl/shared_comparator_arbiter.sv
// One comparator shared by NUM_REQ requesters with round-robin grant and a tagged response.
// Define SHARED_CMP_ARB_STATS_EN to add the saturating cmp_count output.
module shared_comparator_arbiter
    import shared_comparator_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_lt,
    output logic                     rsp_eq,
    output logic                     rsp_gt
`ifdef SHARED_CMP_ARB_STATS_EN
    ,
    output logic [31:0]              cmp_count
`endif
);

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [WIDTH-1:0]   a_q, b_q;
    rsp_t               rsp_q;
    logic               rsp_valid_q;

    logic [NUM_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               eligible, accept;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic               cmp_lt, cmp_eq, cmp_gt;
    logic               unused_rsp_id;

    rr_picker #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_picker (
        .req_valid_i(req_valid),
        .ptr_i      (ptr_q),
        .grant_o    (gnt_oh),
        .idx_o      (gnt_idx),
        .any_o      (gnt_any)
    );

    unsigned_comparator #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a_i (a_q),
        .b_i (b_q),
        .lt_o(cmp_lt),
        .eq_o(cmp_eq),
        .gt_o(cmp_gt)
    );

    // Reset masks the grant so no requester sees a handshake that will be discarded.
    assign eligible  = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    assign accept    = eligible && gnt_any;
    assign req_ready = eligible ? gnt_oh : '0;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= a_sel;
                b_q   <= b_sel;
                id_q  <= gnt_idx;
                ptr_q <= ID_W'(wrap_inc(32'(gnt_idx), NUM_REQ));
            end
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= CMP;
                end
                CMP: begin
                    rsp_q.id    <= RSP_ID_MAX_W'(id_q);
                    rsp_q.lt    <= cmp_lt;
                    rsp_q.eq    <= cmp_eq;
                    rsp_q.gt    <= cmp_gt;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= accept ? CMP : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_q.id[ID_W-1:0];
    assign rsp_lt        = rsp_q.lt;
    assign rsp_eq        = rsp_q.eq;
    assign rsp_gt        = rsp_q.gt;
    assign unused_rsp_id = ^rsp_q.id;

`ifdef SHARED_CMP_ARB_STATS_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rsp_valid_q && rsp_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cmp_count = cnt_q;
`endif

endmodule

// File: tb/tb_shared_comparator_arbiter.sv
// Scoreboard bench for shared_comparator_arbiter: timeline-level reference model plus response monitor.
module tb_shared_comparator_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic           rsp_lt, rsp_eq, rsp_gt;
`ifdef SHARED_CMP_ARB_STATS_EN
    logic [31:0]    cmp_count;
`endif

    always #5 clk = ~clk;

    shared_comparator_arbiter #(
        .WIDTH  (W),
        .NUM_REQ(N),
        .ID_W   (IDW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_lt   (rsp_lt),
        .rsp_eq   (rsp_eq),
        .rsp_gt   (rsp_gt)
`ifdef SHARED_CMP_ARB_STATS_EN
        ,
        .cmp_count(cmp_count)
`endif
    );

    // rel: 0 = a<b, 1 = a==b, 2 = a>b; due = cycle in which rsp_valid must first be seen.
    typedef struct {
        int id;
        int rel;
        int due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   p_m = 0, acc_cyc = 0, exp_cnt = 0;
    bit   busy = 0, log_en = 0;
    int   log_id[$], log_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: who may be granted this cycle, and what response that grant owes.
    task automatic model_step();
        logic [N-1:0] exp_ready;
        logic [W-1:0] av, bv;
        bit           resp_hs, elig;
        int           g, rel;
        exp_ready = '0;
        g = -1;
        if (rst) begin
            busy = 0;
            p_m  = 0;
            sb.delete();
        end else begin
            resp_hs = busy && (cyc >= acc_cyc + 2) && rsp_ready;
            elig    = !busy || resp_hs;
            if (elig)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(p_m + k) % N]) g = (p_m + k) % N;
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                av  = req_a[g*W +: W];
                bv  = req_b[g*W +: W];
                rel = (av < bv) ? 0 : ((av == bv) ? 1 : 2);
                sb.push_back('{g, rel, cyc + 2});
                p_m     = (g + 1) % N;
                busy    = 1;
                acc_cyc = cyc;
                if (log_en) begin
                    log_id.push_back(g);
                    log_cyc.push_back(cyc);
                end
            end else if (resp_hs) begin
                busy = 0;
            end
        end
        chk("req_ready", req_ready, exp_ready);
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        model_step();
    end

    // Monitor: whenever a response is presented, compare against the oldest expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_valid_spurious", rsp_valid, 0);
            end else begin
                e = sb[0];
                chk("rsp_early", (cyc < e.due), 0);
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_lt", rsp_lt, (e.rel == 0));
                chk("rsp_eq", rsp_eq, (e.rel == 1));
                chk("rsp_gt", rsp_gt, (e.rel == 2));
                chk("rsp_onehot", int'(rsp_lt) + int'(rsp_eq) + int'(rsp_gt), 1);
                if (rsp_ready === 1'b1 && rst !== 1'b1) void'(sb.pop_front());
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("rsp_late", rsp_valid, 1);
        end
`ifdef SHARED_CMP_ARB_STATS_EN
        chk("cmp_count", cmp_count, exp_cnt);
`endif
        if (rst === 1'b1) exp_cnt = 0;
        else if (rsp_valid === 1'b1 && rsp_ready === 1'b1) exp_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        got = 0;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
        for (int t = 0; t < 30 && !got; t++) begin
            @(negedge clk);
            #2;
            if (req_valid[id] && req_ready[id]) got = 1;
            else tick();
        end
        chk("send_accepted", got, 1);
        tick();
        req_valid[id] = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_flags", {rsp_lt, rsp_eq, rsp_gt}, 0);
        chk("reset_req_ready", req_ready, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_rsp_valid", rsp_valid, 0);
        end
        tick();

        send(2, 8'h05, 8'h09);
        repeat (4) tick();

        // Fairness from a freshly reset pointer.
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        log_en = 1;
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = rnd_op();
                req_b[i*W +: W] = rnd_op();
            end
            tick();
        end
        req_valid = '0;
        log_en    = 0;
        chk("fair_count", (log_id.size() >= 6), 1);
        for (int i = 0; i < 6 && i < log_id.size(); i++) begin
            chk("fair_order", log_id[i], i % N);
            if (i > 0) chk("fair_spacing", log_cyc[i] - log_cyc[i-1], 2);
        end
        repeat (4) tick();

        // Backpressure with a waiting requester, then same-cycle accept on release.
        rsp_ready = 1'b0;
        send(0, 8'h40, 8'h3F);
        req_a[1*W +: W] = 8'h11;
        req_b[1*W +: W] = 8'h11;
        req_valid[1]    = 1'b1;
        repeat (7) tick();
        rsp_ready = 1'b1;
        send(1, 8'h11, 8'h11);
        repeat (4) tick();

        send(0, 8'hFF, 8'h00);
        send(3, 8'h00, 8'h00);
        send(1, 8'h00, 8'hFF);
        repeat (4) tick();

        // Reset while the compare is in flight.
        send(1, 8'h20, 8'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        tick();
        req_valid = '1;
        @(negedge clk);
        chk("midrst_ptr_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (4) tick();

        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(63) == 0);
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = rnd_op();
                req_b[i*W +: W] = rnd_op();
            end
            tick();
        end

        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) tick();
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_comparator_arbiter.md
Name: shared_comparator_arbiter

Overview:
- Shares one unsigned magnitude comparator between NUM_REQ requesters.
- Round-robin arbitration and valid/ready request handshake; operands are captured into registers.
- One compare per grant. The result is returned on a single tagged response channel with backpressure.
- Sits between compute clients (sorters, min/max trackers, limit checkers) and the comparison datapath.

Parameters:
WIDTH, 8, operand width in bits (>=1)
NUM_REQ, 4, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), width of requester id

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (at most one bit high)
req_a  input  NUM_REQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand b, same packing
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  index of requester that issued this compare
rsp_lt  output  1  a < b (unsigned)
rsp_eq  output  1  a == b
rsp_gt  output  1  a > b

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_lt/eq/gt=0, req_ready=0, RR pointer=0, operand regs=0.
- States:
  - IDLE: accept possible.
  - CMP: comparator evaluates captured operands; lt/eq/gt and id are registered.
  - RESP: rsp_valid=1; outputs held stable until rsp_ready.
- Grant: g = first i with req_valid[i]=1, searching from pointer p upward with wrap (p, p+1, ..., NUM_REQ-1, 0, ..., p-1).
  - req_ready[g]=1 only when accept-eligible. Accept-eligible = state IDLE, or state RESP with rsp_ready=1.
  - All other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept (req_valid[g] & req_ready[g]):
  - Capture req_a/req_b slice g and id g.
  - p <= (g+1) mod NUM_REQ; state -> CMP.
  - p is unchanged on cycles with no accept.
- CMP -> RESP unconditionally after one cycle.
- Latency: accept at edge N, rsp_valid high after edge N+2. Minimum 2 cycles between accepts (back-to-back via the RESP+rsp_ready path).
- RESP with rsp_ready=1:
  - If a request is granted the same cycle, go to CMP.
  - Otherwise go to IDLE; rsp_valid drops next cycle.
- RESP with rsp_ready=0: hold all response outputs; req_ready all 0.
- Exactly one of rsp_lt/eq/gt is high whenever rsp_valid=1.
- Boundaries:
  - No requests: stay IDLE, req_ready=0.
  - All requesters continuously valid: strict rotation 0,1,2,...,NUM_REQ-1,0.
  - Single requester valid: it wins regardless of p.
  - Operands 0 vs 0: eq. All-ones vs 0: gt.
  - Requester dropping req_valid before accept: legal; no grant recorded.
  - rst asserted in any state: in-flight compare and pending response discarded; reset values next cycle.
  - rst has priority over accept.

Optional Feature:
- Macro: SHARED_CMP_ARB_STATS_EN.
- Defined: extra output port cmp_count (32 bits, reset 0). Increments by 1 on each response handshake (rsp_valid & rsp_ready), saturates at 2^32-1, cleared by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state typedef {IDLE, CMP, RESP}, 2-bit encoding
  - default WIDTH/NUM_REQ constants
  - response field bundle typedef (id, lt, eq, gt)
- Sub-module rr_picker (combinational): req_valid, pointer -> one-hot grant plus encoded index.
- Comparison itself is an instance of the existing unsigned_comparator on the captured operand registers.
- Top module holds the FSM, operand/result registers and the optional counter.

Test Plan:
- Reset then idle: no req_valid for 10 cycles -> req_ready=0 and rsp_valid=0 throughout.
- Single request (WIDTH=8, NUM_REQ=4):
  - Requester 2 sends a=8'h05, b=8'h09, accepted at edge N -> rsp_valid after N+2, rsp_id=2, lt=1, eq=0, gt=0.
- Fairness: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1. Accepts every 2 cycles.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0.
  - Then raise rsp_ready with req 1 valid -> same-cycle accept, next response follows 2 cycles later.
- Extremes: a=8'hFF, b=8'h00 -> gt. a=b=8'h00 -> eq. a=8'h00, b=8'hFF -> lt. Exactly one flag high each time.
- Reset mid-operation: assert rst in CMP -> next cycle state IDLE, rsp_valid=0, p=0. With SHARED_CMP_ARB_STATS_EN, cmp_count=0.
